// File: rtl/joy_autoread_pkg.sv
// -----------------------------------------------------------------------------
// snes_joy_pkg
//   Shared types and defaults for the console-side joypad auto-read block.
//   - joy_state_t : auto-read sequencer states
//   - NBITS_DEF   : default number of bits shifted per port per read
// -----------------------------------------------------------------------------
package snes_joy_pkg;

  localparam int NBITS_DEF = 16;

  // IDLE hands the port pins to the CPU; the other three states own them.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_CLK_LO = 2'd2,
    ST_CLK_HI = 2'd3
  } joy_state_t;

endpackage : snes_joy_pkg

// File: rtl/joy_autoread.sv
// -----------------------------------------------------------------------------
// joy_autoread
//   Console-side serial joypad reader. Once per frame (START at vblank, when
//   AUTO_EN is set) it strobes both controller ports, clocks NBITS bits out of
//   each and shifts in both data lines of both ports. The four results are
//   published together at the end of the read so software only ever sees a
//   complete frame. With no read running, the CPU's manual strobe and read
//   clocks pass straight through to the ports.
//
// Ports
//   CLK        : system clock
//   RESET_N    : asynchronous active-low reset
//   ENABLE     : tick qualifier; sequencer timing advances only on ticks
//   AUTO_EN    : auto-read permitted; dropping it aborts a running read
//   START      : one-CLK pulse at vblank start
//   MAN_STRB   : CPU manual latch value
//   MAN_CLK1/2 : CPU manual read clocks (active low)
//   JOY1_DI    : port 1 data, bit0 = D1, bit1 = D2 (1 = pressed)
//   JOY2_DI    : port 2 data, bit0 = D1, bit1 = D2 (1 = pressed)
//   JOY_STRB   : latch to both ports
//   JOY1_CLK   : port 1 clock, idle high
//   JOY2_CLK   : port 2 clock, idle high
//   JOY1_DATA  : result, port 1 D1
//   JOY2_DATA  : result, port 2 D1
//   JOY3_DATA  : result, port 1 D2
//   JOY4_DATA  : result, port 2 D2
//   BUSY       : auto-read in progress
// -----------------------------------------------------------------------------
module joy_autoread
  import snes_joy_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int STRB_TICKS = 12,
  parameter int HALF_TICKS = 128
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             AUTO_EN,
  input  logic             START,
  input  logic             MAN_STRB,
  input  logic             MAN_CLK1,
  input  logic             MAN_CLK2,
  input  logic [1:0]       JOY1_DI,
  input  logic [1:0]       JOY2_DI,
  output logic             JOY_STRB,
  output logic             JOY1_CLK,
  output logic             JOY2_CLK,
  output logic [NBITS-1:0] JOY1_DATA,
  output logic [NBITS-1:0] JOY2_DATA,
  output logic [NBITS-1:0] JOY3_DATA,
  output logic [NBITS-1:0] JOY4_DATA,
  output logic             BUSY
);

  // One tick counter serves both the latch and the clock half-phases, so it
  // is sized for the longer of the two. It restarts on every state entry.
  localparam int TICK_MAX = (STRB_TICKS > HALF_TICKS) ? STRB_TICKS : HALF_TICKS;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int NLANES   = 4;

  localparam logic [TW-1:0] STRB_LAST = TW'(STRB_TICKS - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  joy_state_t      state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;

  // Per-cycle strobes from the sequencer to the shift lanes.
  logic            clear_sr;
  logic            sample;
  logic            commit;

  // Lane order matches the result outputs: port1 D1, port2 D1, port1 D2,
  // port2 D2.
  logic [NLANES-1:0]            lane_di;
  logic [NLANES-1:0][NBITS-1:0] lane_data;

  assign lane_di = {JOY2_DI[1], JOY1_DI[1], JOY2_DI[0], JOY1_DI[0]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    clear_sr = 1'b0;
    sample   = 1'b0;
    commit   = 1'b0;

    unique case (state_q)
      // START is a single-CLK pulse, so it is taken regardless of ENABLE.
      ST_IDLE: begin
        if (START && AUTO_EN) begin
          state_d  = ST_LATCH;
          tick_d   = '0;
          bit_d    = '0;
          clear_sr = 1'b1;
        end
      end

      ST_LATCH: begin
        if (ENABLE) begin
          if (tick_q == STRB_LAST) begin
            state_d = ST_CLK_LO;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      // Data is sampled at the very end of the low half, just before the
      // rising edge that moves the devices on to their next bit.
      ST_CLK_LO: begin
        if (ENABLE) begin
          if (tick_q == HALF_LAST) begin
            sample  = 1'b1;
            state_d = ST_CLK_HI;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_CLK_HI: begin
        if (ENABLE) begin
          if (tick_q == HALF_LAST) begin
            tick_d = '0;
            if (bit_q == BIT_LAST) begin
              commit  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              bit_d   = bit_q + 1'b1;
              state_d = ST_CLK_LO;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything: the partial read is thrown away and the
    // previously published results stay visible.
    if (state_q != ST_IDLE && !AUTO_EN) begin
      state_d  = ST_IDLE;
      tick_d   = '0;
      bit_d    = '0;
      clear_sr = 1'b1;
      sample   = 1'b0;
      commit   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Port pin mux. In IDLE the CPU owns the pins; reset forces IDLE, so the
  // manual values appear on the pins as soon as RESET_N falls.
  // ---------------------------------------------------------------------------
  always_comb begin
    JOY_STRB = MAN_STRB;
    JOY1_CLK = MAN_CLK1;
    JOY2_CLK = MAN_CLK2;

    unique case (state_q)
      ST_IDLE: ;
      ST_LATCH: begin
        JOY_STRB = 1'b1;
        JOY1_CLK = 1'b1;
        JOY2_CLK = 1'b1;
      end
      ST_CLK_LO: begin
        JOY_STRB = 1'b0;
        JOY1_CLK = 1'b0;
        JOY2_CLK = 1'b0;
      end
      ST_CLK_HI: begin
        JOY_STRB = 1'b0;
        JOY1_CLK = 1'b1;
        JOY2_CLK = 1'b1;
      end
      default: ;
    endcase
  end

  assign BUSY = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Shift lanes: one shift register and one result register per data line.
  // Bits arrive MSB-first, so the first sampled bit ends in bit NBITS-1.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    logic [NBITS-1:0] sr_q;
    logic [NBITS-1:0] data_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        sr_q   <= '0;
        data_q <= '0;
      end else begin
        if (clear_sr) begin
          sr_q <= '0;
        end else if (sample) begin
          sr_q <= {sr_q[NBITS-2:0], lane_di[g]};
        end
        // The last sample happened in the preceding CLK_LO, so sr_q already
        // holds the complete word when commit fires.
        if (commit) begin
          data_q <= sr_q;
        end
      end
    end

    assign lane_data[g] = data_q;
  end

  assign JOY1_DATA = lane_data[0];
  assign JOY2_DATA = lane_data[1];
  assign JOY3_DATA = lane_data[2];
  assign JOY4_DATA = lane_data[3];

endmodule : joy_autoread

// File: tb/tb_joy_autoread.sv
// -----------------------------------------------------------------------------
// tb_joy_autoread
//   Self-checking bench for joy_autoread at default parameters. A behavioural
//   controller model on each port serves configurable button words; expected
//   results are queued when a read starts and compared when BUSY falls.
// -----------------------------------------------------------------------------
module tb_joy_autoread;

  localparam int NBITS      = 16;
  localparam int STRB_TICKS = 12;
  localparam int HALF_TICKS = 128;
  localparam int READ_TICKS = STRB_TICKS + NBITS * 2 * HALF_TICKS;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             auto_en;
  logic             start;
  logic             man_strb;
  logic             man_clk1;
  logic             man_clk2;
  logic [1:0]       joy1_di;
  logic [1:0]       joy2_di;
  logic             joy_strb;
  logic             joy1_clk;
  logic             joy2_clk;
  logic [NBITS-1:0] joy1_data;
  logic [NBITS-1:0] joy2_data;
  logic [NBITS-1:0] joy3_data;
  logic [NBITS-1:0] joy4_data;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // Expected {JOY4, JOY3, JOY2, JOY1} words, one entry per started read.
  logic [4*NBITS-1:0] sb_q[$];

  joy_autoread #(
    .NBITS      (NBITS),
    .STRB_TICKS (STRB_TICKS),
    .HALF_TICKS (HALF_TICKS)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .ENABLE    (enable),
    .AUTO_EN   (auto_en),
    .START     (start),
    .MAN_STRB  (man_strb),
    .MAN_CLK1  (man_clk1),
    .MAN_CLK2  (man_clk2),
    .JOY1_DI   (joy1_di),
    .JOY2_DI   (joy2_di),
    .JOY_STRB  (joy_strb),
    .JOY1_CLK  (joy1_clk),
    .JOY2_CLK  (joy2_clk),
    .JOY1_DATA (joy1_data),
    .JOY2_DATA (joy2_data),
    .JOY3_DATA (joy3_data),
    .JOY4_DATA (joy4_data),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ENABLE: every cycle, or one cycle in four when div4 is set.
  logic       div4 = 1'b0;
  logic [1:0] ph   = 2'd0;
  always @(posedge clk) ph <= ph + 2'd1;
  assign enable = !div4 || (ph == 2'd0);

  // Controller model: strobe high loads the button words, each rising port
  // clock moves to the next bit. The current bit is the word's MSB.
  logic [NBITS-1:0] pat1_d1, pat1_d2, pat2_d1, pat2_d2;
  logic [NBITS-1:0] dev1_d1, dev1_d2, dev2_d1, dev2_d2;

  always @(posedge joy1_clk or posedge joy_strb) begin
    if (joy_strb) begin
      dev1_d1 <= pat1_d1;
      dev1_d2 <= pat1_d2;
    end else begin
      dev1_d1 <= dev1_d1 << 1;
      dev1_d2 <= dev1_d2 << 1;
    end
  end

  always @(posedge joy2_clk or posedge joy_strb) begin
    if (joy_strb) begin
      dev2_d1 <= pat2_d1;
      dev2_d2 <= pat2_d2;
    end else begin
      dev2_d1 <= dev2_d1 << 1;
      dev2_d2 <= dev2_d2 << 1;
    end
  end

  assign joy1_di = {dev1_d2[NBITS-1], dev1_d1[NBITS-1]};
  assign joy2_di = {dev2_d2[NBITS-1], dev2_d1[NBITS-1]};

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic set_patterns(input logic [NBITS-1:0] p1d1, p2d1, p1d2, p2d2);
    pat1_d1 = p1d1;
    pat2_d1 = p2d1;
    pat1_d2 = p1d2;
    pat2_d2 = p2d2;
  endtask

  // Raise START on a negedge where ENABLE is high; lowered by the caller.
  task automatic raise_start();
    @(negedge clk);
    while (!enable) @(negedge clk);
    start = 1'b1;
  endtask

  task automatic check_results(input string tag);
    logic [4*NBITS-1:0] exp;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard: no expected entry queued", tag);
    end else begin
      exp = sb_q.pop_front();
      total++;
      if (joy1_data !== exp[0*NBITS +: NBITS]) begin
        bad++;
        $display("FAIL %s joy1_data: got %h want %h", tag, joy1_data, exp[0*NBITS +: NBITS]);
      end
      total++;
      if (joy2_data !== exp[1*NBITS +: NBITS]) begin
        bad++;
        $display("FAIL %s joy2_data: got %h want %h", tag, joy2_data, exp[1*NBITS +: NBITS]);
      end
      total++;
      if (joy3_data !== exp[2*NBITS +: NBITS]) begin
        bad++;
        $display("FAIL %s joy3_data: got %h want %h", tag, joy3_data, exp[2*NBITS +: NBITS]);
      end
      total++;
      if (joy4_data !== exp[3*NBITS +: NBITS]) begin
        bad++;
        $display("FAIL %s joy4_data: got %h want %h", tag, joy4_data, exp[3*NBITS +: NBITS]);
      end
    end
  endtask

  // Full auto-read: checks busy length, strobe length, every clock low
  // pulse and the committed words. extra_start fires a second START mid-read.
  task automatic run_read(input logic [NBITS-1:0] p1d1, p2d1, p1d2, p2d2,
                          input int scale, input bit extra_start, input string tag);
    int   busy_cnt = 0;
    int   strb_cnt = 0;
    int   pulses   = 0;
    int   run      = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;
    bit   done     = 1'b0;
    logic prev_clk = 1'b1;

    set_patterns(p1d1, p2d1, p1d2, p2d2);
    sb_q.push_back({p2d2, p1d2, p2d1, p1d1});
    raise_start();
    while (!done && cyc < READ_TICKS * scale + 200) begin
      @(negedge clk);
      cyc++;
      start = extra_start && (cyc == 2000);
      if (busy) begin
        seen = 1'b1;
        busy_cnt++;
        if (joy_strb) strb_cnt++;
        if (!joy1_clk) begin
          run++;
        end else if (!prev_clk) begin
          pulses++;
          total++;
          if (run !== HALF_TICKS * scale) begin
            bad++;
            $display("FAIL %s clk_low_%0d: got %0d cycles want %0d", tag, pulses, run, HALF_TICKS * scale);
          end
          run = 0;
        end
        prev_clk = joy1_clk;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    start = 1'b0;

    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: busy never completed after %0d cycles", tag, cyc);
    end
    total++;
    if (busy_cnt !== READ_TICKS * scale) begin
      bad++;
      $display("FAIL %s busy_len: got %0d want %0d", tag, busy_cnt, READ_TICKS * scale);
    end
    total++;
    if (strb_cnt !== STRB_TICKS * scale) begin
      bad++;
      $display("FAIL %s strb_len: got %0d want %0d", tag, strb_cnt, STRB_TICKS * scale);
    end
    total++;
    if (pulses !== NBITS) begin
      bad++;
      $display("FAIL %s clk_pulses: got %0d want %0d", tag, pulses, NBITS);
    end
    check_results(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    man_strb = 1'b1;
    man_clk1 = 1'b0;
    man_clk2 = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset busy: got %b want 0", busy);
    end
    total++;
    if ({joy1_data, joy2_data, joy3_data, joy4_data} !== '0) begin
      bad++;
      $display("FAIL reset data: got %h %h %h %h want 0", joy1_data, joy2_data, joy3_data, joy4_data);
    end
    total++;
    if ({joy_strb, joy1_clk, joy2_clk} !== 3'b101) begin
      bad++;
      $display("FAIL reset pins: got %b want 101", {joy_strb, joy1_clk, joy2_clk});
    end
    man_strb = 1'b0;
    man_clk1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_read();
    run_read(16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF, 1, 1'b0, "basic");
  endtask

  task automatic test_start_gating();
    int busy_seen = 0;
    auto_en = 1'b0;
    raise_start();
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    total++;
    if (busy_seen !== 0) begin
      bad++;
      $display("FAIL start_no_autoen: busy cycles got %0d want 0", busy_seen);
    end
    auto_en = 1'b1;
    run_read(16'h3C5A, 16'h00F0, 16'h0F0F, 16'h1111, 1, 1'b1, "start_while_busy");
  endtask

  task automatic test_abort();
    int falls = 0;
    int cyc   = 0;
    logic prev_clk = 1'b1;

    run_read(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1, 1'b0, "pre_abort");
    set_patterns(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    raise_start();
    @(negedge clk);
    start = 1'b0;
    // Eighth falling port clock means the read is on bit 7.
    while (falls < 8 && cyc < READ_TICKS) begin
      @(negedge clk);
      cyc++;
      if (prev_clk && !joy1_clk && busy) falls++;
      prev_clk = joy1_clk;
    end
    total++;
    if (falls !== 8) begin
      bad++;
      $display("FAIL abort reach_bit7: falls got %0d want 8", falls);
    end
    repeat (10) @(negedge clk);
    auto_en  = 1'b0;
    man_clk1 = 1'b0;
    man_clk2 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort busy: got %b want 0", busy);
    end
    total++;
    if ({joy1_data, joy2_data, joy3_data, joy4_data} !== {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}) begin
      bad++;
      $display("FAIL abort data: got %h %h %h %h want 1234 5678 9abc def0",
               joy1_data, joy2_data, joy3_data, joy4_data);
    end
    total++;
    if ({joy1_clk, joy2_clk} !== 2'b01) begin
      bad++;
      $display("FAIL abort clocks: got %b want 01", {joy1_clk, joy2_clk});
    end
    man_clk1 = 1'b1;
    auto_en  = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_manual_passthrough();
    logic [2:0] v;
    // IDLE: every manual combination appears on the pins without a clock edge.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      man_strb = v[2];
      man_clk1 = v[1];
      man_clk2 = v[0];
      #1;
      total++;
      if ({joy_strb, joy1_clk, joy2_clk} !== v) begin
        bad++;
        $display("FAIL manual_idle_%0d: got %b want %b", i, {joy_strb, joy1_clk, joy2_clk}, v);
      end
    end
    man_strb = 1'b0;
    man_clk1 = 1'b1;
    man_clk2 = 1'b1;

    // Busy: manual inputs must not reach the pins.
    set_patterns(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
    raise_start();
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    man_strb = 1'b0;
    man_clk1 = 1'b0;
    #1;
    total++;
    if ({busy, joy_strb, joy1_clk} !== 3'b111) begin
      bad++;
      $display("FAIL manual_busy_latch: busy/strb/clk got %b want 111", {busy, joy_strb, joy1_clk});
    end
    repeat (20) @(negedge clk);
    man_strb = 1'b1;
    man_clk1 = 1'b1;
    #1;
    total++;
    if ({busy, joy_strb, joy1_clk} !== 3'b100) begin
      bad++;
      $display("FAIL manual_busy_clklo: busy/strb/clk got %b want 100", {busy, joy_strb, joy1_clk});
    end
  endtask

  // Continues from the read left running in CLK_LO by the manual test.
  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset busy: got %b want 0", busy);
    end
    total++;
    if ({joy1_data, joy2_data, joy3_data, joy4_data} !== '0) begin
      bad++;
      $display("FAIL async_reset data: got %h %h %h %h want 0", joy1_data, joy2_data, joy3_data, joy4_data);
    end
    total++;
    if ({joy_strb, joy1_clk} !== 2'b11) begin
      bad++;
      $display("FAIL async_reset pins: got %b want 11", {joy_strb, joy1_clk});
    end
    man_strb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_enable_div4();
    div4 = 1'b1;
    run_read(16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF, 4, 1'b0, "div4");
    div4 = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    auto_en  = 1'b1;
    start    = 1'b0;
    man_strb = 1'b0;
    man_clk1 = 1'b1;
    man_clk2 = 1'b1;
    set_patterns('0, '0, '0, '0);

    test_reset();
    test_basic_read();
    test_start_gating();
    test_abort();
    test_manual_passthrough();
    test_async_reset();
    test_enable_div4();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_joy_autoread
